// File: rtl/imm_materializer.sv
// Turns a (rd, 16-bit constant, byte mask) request into an LLB/LHB instruction pair.
// The low byte is always issued first; each word is held until the consumer takes it.
module imm_materializer #(
  parameter logic [3:0]  LLB_OPCODE = 4'hB,
  parameter logic [3:0]  LHB_OPCODE = 4'hA,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_rd,
  input  logic [15:0]      req_value,
  input  logic [1:0]       req_mask,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [15:0]      instr,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] issued_count
);

  typedef enum logic [1:0] {StIdle, StIssueLo, StIssueHi} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e     state_q;
  logic [3:0] rd_q;
  logic [7:0] hi_byte_q;
  logic       want_hi_q;

  // The low word is built straight from the request so it is valid the cycle after accept;
  // only what the high word needs is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_q         <= 4'h0;
      hi_byte_q    <= 8'h00;
      want_hi_q    <= 1'b0;
      req_ready    <= 1'b1;
      instr_valid  <= 1'b0;
      instr        <= 16'h0000;
      done         <= 1'b0;
      busy         <= 1'b0;
      issued_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            rd_q      <= req_rd;
            hi_byte_q <= req_value[15:8];
            want_hi_q <= req_mask[1];
            if (req_mask[0]) begin
              state_q     <= StIssueLo;
              instr       <= {LLB_OPCODE, req_rd, req_value[7:0]};
              instr_valid <= 1'b1;
              req_ready   <= 1'b0;
              busy        <= 1'b1;
            end else if (req_mask[1]) begin
              state_q     <= StIssueHi;
              instr       <= {LHB_OPCODE, req_rd, req_value[15:8]};
              instr_valid <= 1'b1;
              req_ready   <= 1'b0;
              busy        <= 1'b1;
            end else begin
              // Empty mask: nothing to emit, just acknowledge completion.
              done <= 1'b1;
            end
          end
        end
        StIssueLo: begin
          if (instr_ready) begin
            issued_count <= issued_count + CntOne;
            if (want_hi_q) begin
              state_q <= StIssueHi;
              instr   <= {LHB_OPCODE, rd_q, hi_byte_q};
            end else begin
              state_q     <= StIdle;
              instr_valid <= 1'b0;
              req_ready   <= 1'b1;
              busy        <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        StIssueHi: begin
          if (instr_ready) begin
            issued_count <= issued_count + CntOne;
            state_q      <= StIdle;
            instr_valid  <= 1'b0;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_materializer.sv
// Bench for imm_materializer: directed cases followed by random traffic against a
// transaction-level model (queue of expected instruction words).
module tb_imm_materializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_rd;
  logic [15:0] req_value;
  logic [1:0]  req_mask;
  logic        instr_ready;

  logic        req_ready, instr_valid, done, busy;
  logic [15:0] instr;
  logic [15:0] issued_count;
  logic        req_ready4, instr_valid4, done4, busy4;
  logic [15:0] instr4;
  logic [3:0]  issued_count4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imm_materializer dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rd       (req_rd),
    .req_value    (req_value),
    .req_mask     (req_mask),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .done         (done),
    .busy         (busy),
    .issued_count (issued_count)
  );

  // Narrow counter copy so the wrap from 15 to 0 is exercised often.
  imm_materializer #(.CNT_W(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready4),
    .req_rd       (req_rd),
    .req_value    (req_value),
    .req_mask     (req_mask),
    .instr_valid  (instr_valid4),
    .instr_ready  (instr_ready),
    .instr        (instr4),
    .done         (done4),
    .busy         (busy4),
    .issued_count (issued_count4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] rd, input logic [15:0] val, input logic [1:0] mask);
    req_valid = 1'b1;
    req_rd    = rd;
    req_value = val;
    req_mask  = mask;
    step();
    req_valid = 1'b0;
  endtask

  function automatic logic [15:0] word(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  logic [15:0] q_word[$];
  bit          q_last[$];
  logic [15:0] exp_cnt;
  bit          exp_done;
  bit          expect_valid;
  bit          is_last;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rd = '0; req_value = '0; req_mask = '0;
    instr_ready = 1'b1;
    step(); step();
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_instr_valid", instr_valid, 0);
    check_eq("rst_instr", instr, 16'h0000);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_count", issued_count, 0);
    rst = 1'b0;
    step();

    // Full mask, consumer always ready.
    send(4'd3, 16'hBEEF, 2'b11);
    check_eq("full_lo_valid", instr_valid, 1);
    check_eq("full_lo_instr", instr, 16'hB3EF);
    check_eq("full_lo_busy", busy, 1);
    check_eq("full_lo_req_ready", req_ready, 0);
    step();
    check_eq("full_hi_valid", instr_valid, 1);
    check_eq("full_hi_instr", instr, 16'hA3BE);
    step();
    check_eq("full_done", done, 1);
    check_eq("full_count", issued_count, 2);
    check_eq("full_count4", issued_count4, 2);
    check_eq("full_req_ready", req_ready, 1);
    check_eq("full_valid_drop", instr_valid, 0);
    step();
    check_eq("full_done_pulse", done, 0);

    // Low byte only.
    send(4'd7, 16'h1234, 2'b01);
    check_eq("lo_instr", instr, 16'hB734);
    check_eq("lo_valid", instr_valid, 1);
    step();
    check_eq("lo_done", done, 1);
    check_eq("lo_no_lhb", instr_valid, 0);
    check_eq("lo_count", issued_count, 3);
    step();

    // High byte only.
    send(4'd0, 16'h80FF, 2'b10);
    check_eq("hi_instr", instr, 16'hA080);
    check_eq("hi_valid", instr_valid, 1);
    step();
    check_eq("hi_done", done, 1);
    check_eq("hi_count", issued_count, 4);
    step();

    // Empty mask.
    send(4'd5, 16'h5555, 2'b00);
    check_eq("none_done", done, 1);
    check_eq("none_valid", instr_valid, 0);
    check_eq("none_busy", busy, 0);
    check_eq("none_count", issued_count, 4);
    check_eq("none_instr_kept", instr, 16'hA080);
    step();
    check_eq("none_done_pulse", done, 0);

    // Backpressure during the low word.
    instr_ready = 1'b0;
    send(4'd3, 16'hBEEF, 2'b11);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_instr", instr, 16'hB3EF);
      check_eq("bp_valid", instr_valid, 1);
      check_eq("bp_req_ready", req_ready, 0);
      step();
    end
    check_eq("bp_count_held", issued_count, 4);
    instr_ready = 1'b1;
    step();
    check_eq("bp_hi_instr", instr, 16'hA3BE);
    check_eq("bp_hi_req_ready", req_ready, 0);
    step();
    check_eq("bp_done", done, 1);
    check_eq("bp_count", issued_count, 6);
    step();

    // Reset while the high word is pending.
    send(4'd3, 16'hBEEF, 2'b11);
    step();
    check_eq("rhi_instr", instr, 16'hA3BE);
    instr_ready = 1'b0;
    rst = 1'b1;
    step();
    check_eq("rhi_valid", instr_valid, 0);
    check_eq("rhi_busy", busy, 0);
    check_eq("rhi_count", issued_count, 0);
    check_eq("rhi_req_ready", req_ready, 1);
    rst = 1'b0;
    instr_ready = 1'b1;
    step();
    check_eq("rhi_done_none", done, 0);
    send(4'd3, 16'hBEEF, 2'b11);
    check_eq("post_lo_instr", instr, 16'hB3EF);
    step();
    check_eq("post_hi_instr", instr, 16'hA3BE);
    step();
    check_eq("post_done", done, 1);
    check_eq("post_count", issued_count, 2);

    // Random traffic; the model is a queue of words still owed to the consumer.
    exp_cnt  = 16'd2;
    exp_done = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      expect_valid = (q_word.size() != 0);
      check_eq("rnd_valid", instr_valid, expect_valid);
      check_eq("rnd_valid4", instr_valid4, expect_valid);
      if (expect_valid) check_eq("rnd_instr", instr, q_word[0]);
      check_eq("rnd_req_ready", req_ready, !expect_valid);
      check_eq("rnd_busy", busy, expect_valid);
      check_eq("rnd_done", done, exp_done);
      check_eq("rnd_count", issued_count, exp_cnt);
      check_eq("rnd_count4", issued_count4, exp_cnt % 16);

      exp_done    = 1'b0;
      instr_ready = ($urandom_range(0, 3) != 0);
      if (expect_valid && instr_ready) begin
        is_last = q_last.pop_front();
        void'(q_word.pop_front());
        exp_cnt++;
        if (is_last) exp_done = 1'b1;
      end
      req_valid = ($urandom_range(0, 1) == 1);
      req_rd    = 4'($urandom);
      req_value = 16'($urandom);
      req_mask  = 2'($urandom);
      if (req_valid && !expect_valid) begin
        if (req_mask[0]) begin
          q_word.push_back(word(4'hB, req_rd, req_value[7:0]));
          q_last.push_back(!req_mask[1]);
        end
        if (req_mask[1]) begin
          q_word.push_back(word(4'hA, req_rd, req_value[15:8]));
          q_last.push_back(1'b1);
        end
        if (req_mask == 2'b00) exp_done = 1'b1;
      end
      step();
    end

    // Drain with a bounded budget.
    req_valid   = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && instr_valid; i++) begin
      check_eq("drain_instr", instr, q_word.size() != 0 ? q_word[0] : 16'hxxxx);
      if (q_word.size() != 0) begin
        void'(q_word.pop_front());
        void'(q_last.pop_front());
        exp_cnt++;
      end
      step();
    end
    check_eq("drain_idle", instr_valid, 0);
    check_eq("drain_queue_empty", q_word.size(), 0);
    check_eq("drain_count", issued_count, exp_cnt);
    check_eq("drain_count4", issued_count4, exp_cnt % 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
